// File: rtl/branch_pred_btb.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Lookup is combinational; updates and invalidates take effect at the next rising edge.
module branch_pred_btb #(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 64
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  input  logic            lookup_en_i,
  input  logic [XLEN-1:0] lookup_pc_i,
  output logic            hit_o,
  output logic [XLEN-1:0] target_o,
  input  logic            upd_valid_i,
  input  logic [XLEN-1:0] upd_pc_i,
  input  logic [XLEN-1:0] upd_target_i,
  input  logic            upd_taken_i,
  input  logic            inv_i,
  output logic [31:0]     hit_cnt_o,
  output logic [31:0]     upd_cnt_o
);

  localparam int IDXW = $clog2(ENTRIES);
  localparam int TAGW = XLEN - IDXW - 1;

  logic            r_valid  [ENTRIES];
  logic [TAGW-1:0] r_tag    [ENTRIES];
  logic [XLEN-1:0] r_target [ENTRIES];
  logic [1:0]      r_ctr    [ENTRIES];
  logic [31:0]     r_hit_cnt;
  logic [31:0]     r_upd_cnt;

  // Halfword-granular indexing so compressed instructions get distinct entries.
  logic [IDXW-1:0] w_lidx;
  logic [TAGW-1:0] w_ltag;
  logic [IDXW-1:0] w_uidx;
  logic [TAGW-1:0] w_utag;
  logic            w_lhit;
  logic            w_umatch;

  assign w_lidx = lookup_pc_i[IDXW:1];
  assign w_ltag = lookup_pc_i[XLEN-1:IDXW+1];
  assign w_uidx = upd_pc_i[IDXW:1];
  assign w_utag = upd_pc_i[XLEN-1:IDXW+1];

  assign w_lhit   = r_valid[w_lidx] && (r_tag[w_lidx] == w_ltag) && r_ctr[w_lidx][1];
  assign w_umatch = r_valid[w_uidx] && (r_tag[w_uidx] == w_utag);

  assign hit_o    = rstn_i & w_lhit;
  assign target_o = hit_o ? r_target[w_lidx] : '0;

  // Invalidate has priority over a same-cycle update, which is then dropped.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_ctr[i]    <= 2'b01;
      end
    end else if (inv_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i] <= 1'b0;
      end
    end else if (upd_valid_i) begin
      if (w_umatch) begin
        if (upd_taken_i) begin
          r_target[w_uidx] <= upd_target_i;
          if (r_ctr[w_uidx] != 2'b11) begin
            r_ctr[w_uidx] <= r_ctr[w_uidx] + 2'd1;
          end
        end else if (r_ctr[w_uidx] != 2'b00) begin
          r_ctr[w_uidx] <= r_ctr[w_uidx] - 2'd1;
        end
      end else if (upd_taken_i) begin
        r_valid[w_uidx]  <= 1'b1;
        r_tag[w_uidx]    <= w_utag;
        r_target[w_uidx] <= upd_target_i;
        r_ctr[w_uidx]    <= 2'b10;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_hit_cnt <= '0;
      r_upd_cnt <= '0;
    end else begin
      if (lookup_en_i && hit_o) begin
        r_hit_cnt <= r_hit_cnt + 32'd1;
      end
      if (upd_valid_i && !inv_i) begin
        r_upd_cnt <= r_upd_cnt + 32'd1;
      end
    end
  end

  assign hit_cnt_o = r_hit_cnt;
  assign upd_cnt_o = r_upd_cnt;

endmodule

// File: tb/tb_branch_pred_btb.sv
// Directed bench for branch_pred_btb: expected lookups and counters are queued per step
// and popped for comparison against the DUT mid-cycle.
module tb_branch_pred_btb;

  logic        clk_i = 1'b0;
  logic        rstn_i = 1'b0;
  logic        lookup_en_i = 1'b0;
  logic [31:0] lookup_pc_i = '0;
  logic        hit_o;
  logic [31:0] target_o;
  logic        upd_valid_i = 1'b0;
  logic [31:0] upd_pc_i = '0;
  logic [31:0] upd_target_i = '0;
  logic        upd_taken_i = 1'b0;
  logic        inv_i = 1'b0;
  logic [31:0] hit_cnt_o;
  logic [31:0] upd_cnt_o;

  typedef struct {
    string       name;
    logic        hit;
    logic [31:0] target;
    logic [31:0] hitCnt;
    logic [31:0] updCnt;
  } exp_t;

  exp_t        scoreboard[$];
  int          testCount = 0;
  int          failCount = 0;
  logic [31:0] expHitCnt = '0;
  logic [31:0] expUpdCnt = '0;

  branch_pred_btb #(.XLEN(32), .ENTRIES(64)) dut (
    .clk_i(clk_i),
    .rstn_i(rstn_i),
    .lookup_en_i(lookup_en_i),
    .lookup_pc_i(lookup_pc_i),
    .hit_o(hit_o),
    .target_o(target_o),
    .upd_valid_i(upd_valid_i),
    .upd_pc_i(upd_pc_i),
    .upd_target_i(upd_target_i),
    .upd_taken_i(upd_taken_i),
    .inv_i(inv_i),
    .hit_cnt_o(hit_cnt_o),
    .upd_cnt_o(upd_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput();
    exp_t e;
    e = scoreboard.pop_front();
    testCount++;
    assert (hit_o === e.hit) else begin
      failCount++;
      $error("FAIL %s hit_o: got %0b want %0b", e.name, hit_o, e.hit);
    end
    testCount++;
    assert (target_o === e.target) else begin
      failCount++;
      $error("FAIL %s target_o: got %h want %h", e.name, target_o, e.target);
    end
    testCount++;
    assert (hit_cnt_o === e.hitCnt) else begin
      failCount++;
      $error("FAIL %s hit_cnt_o: got %0d want %0d", e.name, hit_cnt_o, e.hitCnt);
    end
    testCount++;
    assert (upd_cnt_o === e.updCnt) else begin
      failCount++;
      $error("FAIL %s upd_cnt_o: got %0d want %0d", e.name, upd_cnt_o, e.updCnt);
    end
  endtask

  // Drives one cycle at the falling edge, checks mid-cycle, then advances the counter model
  // for the rising edge that follows.
  task automatic applyStimulus(input string name, input logic rstnVal,
                               input logic lookEn, input logic [31:0] lookPc,
                               input logic updV, input logic [31:0] updPc,
                               input logic [31:0] updTgt, input logic updTaken,
                               input logic inv, input logic expHit,
                               input logic [31:0] expTgt);
    exp_t e;
    @(negedge clk_i);
    rstn_i       = rstnVal;
    lookup_en_i  = lookEn;
    lookup_pc_i  = lookPc;
    upd_valid_i  = updV;
    upd_pc_i     = updPc;
    upd_target_i = updTgt;
    upd_taken_i  = updTaken;
    inv_i        = inv;
    if (!rstnVal) begin
      expHitCnt = '0;
      expUpdCnt = '0;
    end
    #2;
    e.name   = name;
    e.hit    = expHit;
    e.target = expTgt;
    e.hitCnt = expHitCnt;
    e.updCnt = expUpdCnt;
    scoreboard.push_back(e);
    checkOutput();
    if (rstnVal) begin
      if (lookEn && expHit) expHitCnt = expHitCnt + 32'd1;
      if (updV && !inv) expUpdCnt = expUpdCnt + 32'd1;
    end
  endtask

  initial begin
    exp_t e;
    $display("[TB] starting branch_pred_btb bench");
    // Reset held with an update pending: it must never land.
    applyStimulus("inReset0", 1'b0, 1'b1, 32'h8000_0000, 1'b1, 32'h8000_0010, 32'h8000_0100, 1'b1, 1'b0, 1'b0, 32'h0);
    applyStimulus("inReset1", 1'b0, 1'b1, 32'h8000_0010, 1'b1, 32'h8000_0010, 32'h8000_0100, 1'b1, 1'b0, 1'b0, 32'h0);
    applyStimulus("afterReset", 1'b1, 1'b1, 32'h8000_0000, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    applyStimulus("noStaleUpd", 1'b1, 1'b1, 32'h8000_0010, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);

    // Allocate, then walk the counter down to 0 and back up through saturation at 3.
    applyStimulus("allocSameCyc", 1'b1, 1'b1, 32'h8000_0010, 1'b1, 32'h8000_0010, 32'h8000_0100, 1'b1, 1'b0, 1'b0, 32'h0);
    applyStimulus("ctr2Hit",      1'b1, 1'b1, 32'h8000_0010, 1'b1, 32'h8000_0010, 32'h0, 1'b0, 1'b0, 1'b1, 32'h8000_0100);
    applyStimulus("ctr1Miss",     1'b1, 1'b1, 32'h8000_0010, 1'b1, 32'h8000_0010, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    applyStimulus("ctr0Miss",     1'b1, 1'b1, 32'h8000_0010, 1'b1, 32'h8000_0010, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    applyStimulus("ctr0Sat",      1'b1, 1'b1, 32'h8000_0010, 1'b1, 32'h8000_0010, 32'h8000_0200, 1'b1, 1'b0, 1'b0, 32'h0);
    applyStimulus("ctr1Up",       1'b1, 1'b1, 32'h8000_0010, 1'b1, 32'h8000_0010, 32'h8000_0200, 1'b1, 1'b0, 1'b0, 32'h0);
    applyStimulus("ctr2Up",       1'b1, 1'b1, 32'h8000_0010, 1'b1, 32'h8000_0010, 32'h8000_0200, 1'b1, 1'b0, 1'b1, 32'h8000_0200);
    applyStimulus("ctr3Sat",      1'b1, 1'b1, 32'h8000_0010, 1'b1, 32'h8000_0010, 32'h8000_0300, 1'b1, 1'b0, 1'b1, 32'h8000_0200);
    applyStimulus("ctr3Down",     1'b1, 1'b1, 32'h8000_0010, 1'b1, 32'h8000_0010, 32'h0, 1'b0, 1'b0, 1'b1, 32'h8000_0300);
    applyStimulus("ctr2Down",     1'b1, 1'b1, 32'h8000_0010, 1'b1, 32'h8000_0010, 32'h0, 1'b0, 1'b0, 1'b1, 32'h8000_0300);
    applyStimulus("ctr1Final",    1'b1, 1'b1, 32'h8000_0010, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);

    // 0x8000_0010 and 0x8000_0090 share index 8 with 64 entries.
    applyStimulus("aliasPrep",    1'b1, 1'b1, 32'h8000_0010, 1'b1, 32'h8000_0010, 32'h8000_0400, 1'b1, 1'b0, 1'b0, 32'h0);
    applyStimulus("aliasReplace", 1'b1, 1'b1, 32'h8000_0010, 1'b1, 32'h8000_0090, 32'h8000_0500, 1'b1, 1'b0, 1'b1, 32'h8000_0400);
    applyStimulus("aliasOldMiss", 1'b1, 1'b1, 32'h8000_0010, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    applyStimulus("aliasNewHit",  1'b1, 1'b1, 32'h8000_0090, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h8000_0500);

    applyStimulus("sameCycle20",  1'b1, 1'b1, 32'h8000_0020, 1'b1, 32'h8000_0020, 32'h8000_0600, 1'b1, 1'b0, 1'b0, 32'h0);
    applyStimulus("nextCycle20",  1'b1, 1'b1, 32'h8000_0020, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h8000_0600);
    // 0x8000_00A0 aliases 0x8000_0020; a not-taken miss must leave the entry alone.
    applyStimulus("missNotTaken", 1'b1, 1'b1, 32'h8000_0020, 1'b1, 32'h8000_00A0, 32'h8000_0A00, 1'b0, 1'b0, 1'b1, 32'h8000_0600);
    applyStimulus("missNoChange", 1'b1, 1'b1, 32'h8000_0020, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h8000_0600);
    applyStimulus("lookupGated",  1'b1, 1'b0, 32'h8000_0020, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h8000_0600);

    // Invalidate races an update; the update is dropped and nothing hits afterwards.
    applyStimulus("invWithUpd",   1'b1, 1'b1, 32'h8000_0090, 1'b1, 32'h8000_0030, 32'h8000_0700, 1'b1, 1'b1, 1'b1, 32'h8000_0500);
    applyStimulus("invMiss90",    1'b1, 1'b1, 32'h8000_0090, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    applyStimulus("invMiss20",    1'b1, 1'b1, 32'h8000_0020, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    applyStimulus("invDropped30", 1'b1, 1'b1, 32'h8000_0030, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);

    // Reset asserted asynchronously just ahead of the edge that would take an update.
    applyStimulus("preMidReset",  1'b1, 1'b1, 32'h8000_0040, 1'b1, 32'h8000_0040, 32'h8000_0800, 1'b1, 1'b0, 1'b0, 32'h0);
    #1;
    rstn_i = 1'b0;
    expHitCnt = '0;
    expUpdCnt = '0;
    #1;
    e.name   = "asyncReset";
    e.hit    = 1'b0;
    e.target = 32'h0;
    e.hitCnt = expHitCnt;
    e.updCnt = expUpdCnt;
    scoreboard.push_back(e);
    checkOutput();
    applyStimulus("midResetHeld", 1'b0, 1'b1, 32'h8000_0040, 1'b1, 32'h8000_0040, 32'h8000_0800, 1'b1, 1'b0, 1'b0, 32'h0);
    applyStimulus("firstUpdate",  1'b1, 1'b1, 32'h8000_0040, 1'b1, 32'h8000_0040, 32'h8000_0900, 1'b1, 1'b0, 1'b0, 32'h0);
    applyStimulus("firstUpdHit",  1'b1, 1'b1, 32'h8000_0040, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h8000_0900);
    applyStimulus("finalCounts",  1'b1, 1'b0, 32'h8000_0000, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/branch_pred_btb.md
BRANCH_PRED_BTB -- requirements
Module: branch_pred_btb

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning the address and data width.
REQ-002 The block SHALL have parameter ENTRIES, default 64, meaning the number of direct-mapped entries (power of 2, 2..1024).
REQ-003 The block SHALL have port clk_i, input, width 1, the single clock, with all state updated on its rising edge.
REQ-004 The block SHALL have port rstn_i, input, width 1, the reset, asynchronous and active-low.
REQ-005 The block SHALL have port lookup_en_i, input, width 1, asserted when fetch advances (not stalled, not flushed).
REQ-006 The block SHALL have port lookup_pc_i, input, width XLEN, the current fetch PC.
REQ-007 The block SHALL have port hit_o, output, width 1, the predict-taken indication to fetch.
REQ-008 The block SHALL have port target_o, output, width XLEN, the predicted target address.
REQ-009 The block SHALL have port upd_valid_i, input, width 1, a resolved control-transfer update from execute.
REQ-010 The block SHALL have port upd_pc_i, input, width XLEN, the PC of the resolved branch or jump.
REQ-011 The block SHALL have port upd_target_i, input, width XLEN, the resolved target.
REQ-012 The block SHALL have port upd_taken_i, input, width 1, the resolved direction.
REQ-013 The block SHALL have port inv_i, input, width 1, a synchronous invalidate of all entries (fence.i).
REQ-014 The block SHALL have port hit_cnt_o, output, width 32, the count of predicted-taken lookups.
REQ-015 The block SHALL have port upd_cnt_o, output, width 32, the count of accepted updates.

Function
REQ-016 IDXW = log2(ENTRIES); the index SHALL be pc[IDXW:1] (halfword granularity, because compressed instructions are supported), and the tag SHALL be pc[XLEN-1:IDXW+1].
REQ-017 Each entry SHALL hold: valid (1 bit), tag, target (XLEN bits), and a 2-bit saturating counter ctr.
REQ-018 The lookup SHALL be combinational: hit_o = valid & tag match & ctr[1]; target_o = the entry's target.
REQ-019 When hit_o = 0, target_o SHALL be driven to 0.
REQ-020 hit_o SHALL not depend on lookup_en_i; only hit_cnt_o is gated by lookup_en_i.
REQ-021 On an update with tag match and upd_taken_i = 1: ctr SHALL be incremented and saturate at 3, and target SHALL be overwritten with upd_target_i.
REQ-022 On an update with tag match and upd_taken_i = 0: ctr SHALL be decremented and saturate at 0, with target unchanged and valid kept.
REQ-023 On an update with a miss (invalid entry or tag mismatch) and upd_taken_i = 1: the entry SHALL be allocated or replaced with valid = 1, the new tag, target = upd_target_i, and ctr = 2'b10.
REQ-024 On an update with a miss and upd_taken_i = 0: there SHALL be no state change.
REQ-025 Updates SHALL be written at the clock edge; a lookup in the same cycle at the same index SHALL see the pre-update state, with the new state visible on the next cycle.
REQ-026 inv_i SHALL clear every valid bit at the next edge; ctr and target are don't-care after invalidation.
REQ-027 When inv_i and upd_valid_i are both asserted in one cycle, inv_i SHALL win and the update SHALL be dropped.
REQ-028 hit_cnt_o SHALL increment on each edge where lookup_en_i & hit_o, and SHALL wrap from 0xFFFF_FFFF to 0.
REQ-029 upd_cnt_o SHALL increment on each edge with upd_valid_i & !inv_i, and SHALL wrap from 0xFFFF_FFFF to 0.
REQ-030 The counters SHALL be unaffected by inv_i.

Reset
REQ-031 While rstn_i = 0, asynchronously: all valid = 0, all ctr = 2'b01, all target = 0, hit_cnt_o = 0, upd_cnt_o = 0.
REQ-032 While rstn_i = 0: hit_o = 0 and target_o = 0.
REQ-033 When reset is asserted mid-operation, any in-flight update SHALL be discarded.
REQ-034 After deassertion, the first update SHALL be taken at the first rising edge with rstn_i = 1.

Verification
REQ-035 The bench SHALL cover: reset, then lookup_pc_i = 0x8000_0000 -> hit_o = 0, target_o = 0, and both counters 0.
REQ-036 The bench SHALL cover: update pc = 0x8000_0010, target = 0x8000_0100, taken -> on the next cycle, lookup of 0x8000_0010 gives hit_o = 1, target_o = 0x8000_0100, ctr = 2.
REQ-037 The bench SHALL cover: two not-taken updates to 0x8000_0010 -> after the first, hit_o = 0 (ctr = 1); after the second, ctr = 0; then three taken updates -> hit_o = 1 with ctr saturating at 3.
REQ-038 The bench SHALL cover an alias with ENTRIES = 64: update 0x8000_0010 taken, then 0x8000_0090 taken -> lookup of 0x8000_0010 misses and 0x8000_0090 hits.
REQ-039 The bench SHALL cover a same-cycle lookup and first update of 0x8000_0020 -> hit_o = 0 in that cycle and 1 in the next.
REQ-040 The bench SHALL cover inv_i together with upd_valid_i -> all subsequent lookups give hit_o = 0, upd_cnt_o is unchanged, and hit_cnt_o holds its value.
